// File: rtl/seg_pkg.sv
// ============================================================================
// seg_pkg -- shared seven-segment types and active-low digit patterns.
// Revision: 1.0 -- initial release
// ============================================================================
`default_nettype none

package seg_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;

  // Active-low segment patterns, bit0 = a ... bit6 = g
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_HEX_0 = 7'h40;
  localparam seg_t SEG_HEX_1 = 7'h79;
  localparam seg_t SEG_HEX_2 = 7'h24;
  localparam seg_t SEG_HEX_3 = 7'h30;
  localparam seg_t SEG_HEX_4 = 7'h19;
  localparam seg_t SEG_HEX_5 = 7'h12;
  localparam seg_t SEG_HEX_6 = 7'h02;
  localparam seg_t SEG_HEX_7 = 7'h78;
  localparam seg_t SEG_HEX_8 = 7'h00;
  localparam seg_t SEG_HEX_9 = 7'h10;
  localparam seg_t SEG_HEX_A = 7'h20;
  localparam seg_t SEG_HEX_B = 7'h03;
  localparam seg_t SEG_HEX_C = 7'h46;
  localparam seg_t SEG_HEX_D = 7'h21;
  localparam seg_t SEG_HEX_E = 7'h06;
  localparam seg_t SEG_HEX_F = 7'h0E;

endpackage

`default_nettype wire

// File: rtl/seg_pattern_decoder.sv
// ============================================================================
// seg_pattern_decoder -- combinational active-low segment pattern to nibble.
// Revision: 1.0 -- initial release
// ============================================================================
`default_nettype none

module seg_pattern_decoder
  import seg_pkg::*;
(
  input  seg_t    i_seg,
  output nibble_t o_nibble,
  output logic    o_is_hex,
  output logic    o_is_blank
);

  always_comb begin
    o_nibble   = 4'h0;
    o_is_hex   = 1'b1;
    o_is_blank = 1'b0;
    case (i_seg)
      SEG_HEX_0: o_nibble = 4'h0;
      SEG_HEX_1: o_nibble = 4'h1;
      SEG_HEX_2: o_nibble = 4'h2;
      SEG_HEX_3: o_nibble = 4'h3;
      SEG_HEX_4: o_nibble = 4'h4;
      SEG_HEX_5: o_nibble = 4'h5;
      SEG_HEX_6: o_nibble = 4'h6;
      SEG_HEX_7: o_nibble = 4'h7;
      SEG_HEX_8: o_nibble = 4'h8;
      SEG_HEX_9: o_nibble = 4'h9;
      SEG_HEX_A: o_nibble = 4'hA;
      SEG_HEX_B: o_nibble = 4'hB;
      SEG_HEX_C: o_nibble = 4'hC;
      SEG_HEX_D: o_nibble = 4'hD;
      SEG_HEX_E: o_nibble = 4'hE;
      SEG_HEX_F: o_nibble = 4'hF;
      SEG_BLANK: begin
        o_is_hex   = 1'b0;
        o_is_blank = 1'b1;
      end
      default:   o_is_hex = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_decoder.sv
// ============================================================================
// seg_scan_decoder -- recovers hex nibbles from a multiplexed 7-seg drive,
// capturing each digit once its pattern has been stable for STABLE_CYCLES.
// Optional decimal point capture enabled by defining SEG_DP_EN.
// Revision: 1.0 -- initial release
// ============================================================================
`default_nettype none

module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  seg_t                    i_seg,
  input  logic [NUM_DIGITS-1:0]   i_dig_sel,
`ifdef SEG_DP_EN
  input  logic                    i_dp,
  output logic [NUM_DIGITS-1:0]   o_dp,
`endif
  output logic [4*NUM_DIGITS-1:0] o_value,
  output logic [NUM_DIGITS-1:0]   o_valid_mask,
  output logic                    o_update,
  output logic                    o_frame_done,
  output logic                    o_err
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 1);

  seg_t                    s_seg_q, s_seg_d;
  logic [NUM_DIGITS-1:0]   s_sel_q, s_sel_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d, seen_set;
  logic                    update_q, update_d;
  logic                    frame_q, frame_d;
  logic                    err_q, err_d;

  logic    dp_match;
  logic    in_match;
  logic    sel_onehot;
  logic    capture;
  nibble_t dec_nibble;
  logic    dec_is_hex;
  logic    dec_is_blank;

  seg_pattern_decoder u_decoder (
    .i_seg      (s_seg_q),
    .o_nibble   (dec_nibble),
    .o_is_hex   (dec_is_hex),
    .o_is_blank (dec_is_blank)
  );

`ifdef SEG_DP_EN
  logic                  s_dp_q, s_dp_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;

  assign dp_match = (i_dp == s_dp_q);
  assign o_dp     = dp_q;

  always_comb begin
    s_dp_d = i_dp;
    dp_d   = dp_q;
    if (capture) begin
      dp_d = (dp_q & ~s_sel_q) | ({NUM_DIGITS{~s_dp_q}} & s_sel_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s_dp_q <= 1'b1;
      dp_q   <= '0;
    end else begin
      s_dp_q <= s_dp_d;
      dp_q   <= dp_d;
    end
  end
`else
  assign dp_match = 1'b1;
`endif

  assign in_match   = (i_seg == s_seg_q) && (i_dig_sel == s_sel_q) && dp_match;
  assign sel_onehot = (s_sel_q != '0) && ((s_sel_q & (s_sel_q - 1'b1)) == '0);
  // Inputs equal the sampled copy here, so the decoder can look at s_seg_q.
  assign capture    = in_match && (cnt_q == CNT_CAP) && sel_onehot;

  always_comb begin
    s_seg_d  = i_seg;
    s_sel_d  = i_dig_sel;
    cnt_d    = '0;
    value_d  = value_q;
    valid_d  = valid_q;
    seen_set = seen_q;
    seen_d   = seen_q;
    update_d = capture;
    frame_d  = 1'b0;
    err_d    = err_q;

    if (in_match) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    if (capture) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (s_sel_q[k] && dec_is_hex) begin
          value_d[4*k +: 4] = dec_nibble;
        end
      end
      valid_d  = (valid_q & ~s_sel_q) | (dec_is_hex ? s_sel_q : '0);
      seen_set = seen_q | s_sel_q;
      if (!dec_is_hex && !dec_is_blank) begin
        err_d = 1'b1;
      end
    end

    // Completing the frame wins over setting the current seen bit.
    if (capture && (&seen_set)) begin
      frame_d = 1'b1;
      seen_d  = '0;
    end else begin
      seen_d  = seen_set;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s_seg_q  <= SEG_BLANK;
      s_sel_q  <= '0;
      cnt_q    <= '0;
      value_q  <= '0;
      valid_q  <= '0;
      seen_q   <= '0;
      update_q <= 1'b0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s_seg_q  <= s_seg_d;
      s_sel_q  <= s_sel_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
      update_q <= update_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end

  assign o_value      = value_q;
  assign o_valid_mask = valid_q;
  assign o_update     = update_q;
  assign o_frame_done = frame_q;
  assign o_err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
// ============================================================================
// tb_seg_scan_decoder -- directed vectors for seg_scan_decoder (4 digits).
// Revision: 1.0 -- initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg;
  logic [ND-1:0] sel;
  logic [4*ND-1:0] value;
  logic [ND-1:0] mask;
  logic          upd;
  logic          fd;
  logic          err;
`ifdef SEG_DP_EN
  logic          dp;
  logic [ND-1:0] odp;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  int ucnt, uedge, fcnt, fedge;
  int fsum;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_seg        (seg),
    .i_dig_sel    (sel),
`ifdef SEG_DP_EN
    .i_dp         (dp),
    .o_dp         (odp),
`endif
    .o_value      (value),
    .o_valid_mask (mask),
    .o_update     (upd),
    .o_frame_done (fd),
    .o_err        (err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs n edges with current inputs, tallying update / frame pulses.
  task automatic run(input int n, output int uc, output int ue, output int fc, output int fe);
    uc = 0; ue = 0; fc = 0; fe = 0;
    for (int e = 1; e <= n; e++) begin
      step();
      if (upd === 1'b1) begin
        uc++;
        if (ue == 0) ue = e;
      end
      if (fd === 1'b1) begin
        fc++;
        if (fe == 0) fe = e;
        if (upd !== 1'b1) check_val("frame_without_update", {31'd0, upd}, 32'd1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    seg = 7'h7F;
    sel = '0;
`ifdef SEG_DP_EN
    dp  = 1'b1;
`endif
    step();
    step();
    check_val("rst_value", {16'd0, value}, 32'h0);
    check_val("rst_mask",  {28'd0, mask},  32'h0);
    check_val("rst_update", {31'd0, upd},  32'h0);
    check_val("rst_frame",  {31'd0, fd},   32'h0);
    check_val("rst_err",    {31'd0, err},  32'h0);

    // Held pattern: single capture at edge SC+1
    rst = 1'b0; sel = 4'b0001; seg = 7'h30;
    run(6, ucnt, uedge, fcnt, fedge);
    check_val("hold_upd_count", ucnt,  1);
    check_val("hold_upd_edge",  uedge, 5);
    check_val("hold_value",     {16'd0, value}, 32'h0003);
    check_val("hold_mask",      {28'd0, mask},  32'h1);
    check_val("hold_frame",     fcnt, 0);

    // Full scan
    fsum = 0;
    sel = 4'b0001; seg = 7'h40;
    run(5, ucnt, uedge, fcnt, fedge);
    check_val("scan0_upd", ucnt, 1); fsum += fcnt;
    sel = 4'b0010; seg = 7'h79;
    run(5, ucnt, uedge, fcnt, fedge);
    check_val("scan1_upd", ucnt, 1); fsum += fcnt;
    sel = 4'b0100; seg = 7'h0E;
    run(5, ucnt, uedge, fcnt, fedge);
    check_val("scan2_upd", ucnt, 1); fsum += fcnt;
    check_val("scan_early_frame", fsum, 0);
    sel = 4'b1000; seg = 7'h21;
    run(5, ucnt, uedge, fcnt, fedge);
    check_val("scan3_upd_edge", uedge, 5);
    check_val("scan3_frame_cnt", fcnt, 1);
    check_val("scan3_frame_edge", fedge, 5);
    check_val("scan_value", {16'd0, value}, 32'hDF10);
    check_val("scan_mask",  {28'd0, mask},  32'hF);

    // Toggling every 3 cycles never stabilises
    sel = 4'b0001;
    fsum = 0;
    for (int i = 0; i < 4; i++) begin
      seg = (i % 2 == 0) ? 7'h40 : 7'h79;
      run(3, ucnt, uedge, fcnt, fedge);
      fsum += ucnt;
    end
    check_val("toggle_no_upd", fsum, 0);
    check_val("toggle_value", {16'd0, value}, 32'hDF10);

    // Unrecognised pattern, then blank
    sel = 4'b0100; seg = 7'h7E;
    run(6, ucnt, uedge, fcnt, fedge);
    check_val("bad_upd", ucnt, 1);
    check_val("bad_err", {31'd0, err}, 32'h1);
    check_val("bad_mask", {28'd0, mask}, 32'hB);
    check_val("bad_value", {16'd0, value}, 32'hDF10);
    seg = 7'h7F;
    run(6, ucnt, uedge, fcnt, fedge);
    check_val("blank_upd", ucnt, 1);
    check_val("blank_err", {31'd0, err}, 32'h1);
    check_val("blank_mask", {28'd0, mask}, 32'hB);
    check_val("blank_value", {16'd0, value}, 32'hDF10);

    // Multi-hot select never captures
    sel = 4'b0011; seg = 7'h40;
    run(10, ucnt, uedge, fcnt, fedge);
    check_val("multihot_no_upd", ucnt, 0);
    check_val("multihot_mask", {28'd0, mask}, 32'hB);

    // Reset mid-count, then capture 5 edges after release
    sel = 4'b0001; seg = 7'h24;
    run(3, ucnt, uedge, fcnt, fedge);
    check_val("precount_no_upd", ucnt, 0);
    rst = 1'b1;
    step();
    check_val("midrst_value", {16'd0, value}, 32'h0);
    check_val("midrst_mask",  {28'd0, mask},  32'h0);
    check_val("midrst_err",   {31'd0, err},   32'h0);
    check_val("midrst_upd",   {31'd0, upd},   32'h0);
    rst = 1'b0;
    run(6, ucnt, uedge, fcnt, fedge);
    check_val("postrst_upd_count", ucnt, 1);
    check_val("postrst_upd_edge",  uedge, 5);
    check_val("postrst_value", {16'd0, value}, 32'h0002);
    check_val("postrst_mask",  {28'd0, mask},  32'h1);

`ifdef SEG_DP_EN
    sel = 4'b0001; seg = 7'h12; dp = 1'b0;
    run(6, ucnt, uedge, fcnt, fedge);
    check_val("dp_value", {16'd0, value}, 32'h0005);
    check_val("dp_out",   {28'd0, odp},   32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Recovers hex digit values from a time-multiplexed, active-low seven-segment display drive: anode select plus shared segment bus. It is the read-back end of the hex-to-segment encoding used on the board display path. It sits beside the display driver in the top level and in test harnesses, so the processor's displayed state can be checked and logged as nibbles. Each digit is captured only after its pattern has been stable for a programmable number of cycles, which rejects scan-transition glitches.

## Interface
- NUM_DIGITS, 8, number of multiplexed digits (1..16)
- STABLE_CYCLES, 4, consecutive unchanged cycles required before capture (>=1)
- i_clk  in  1  clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_seg  in  7  segment bus, active-low, bit0=a … bit6=g
- i_dig_sel  in  NUM_DIGITS  digit select, active-high, one-hot when valid
- o_value  out  4*NUM_DIGITS  captured nibbles, digit k at [4k+3:4k]
- o_valid_mask  out  NUM_DIGITS  bit k set = digit k holds a decoded hex value
- o_update  out  1  one-cycle pulse on any digit capture
- o_frame_done  out  1  one-cycle pulse when every digit has been captured since the last pulse
- o_err  out  1  sticky, set on an unrecognised non-blank pattern

## Operation
- Sample stage: each edge registers i_seg/i_dig_sel into s_seg/s_sel. Reset values are 7'h7F and 0.
- Stability counter cnt, width $clog2(STABLE_CYCLES+1):
  - If the inputs equal s_seg/s_sel, cnt increments and saturates at STABLE_CYCLES.
  - Otherwise cnt clears to 0.
- Capture fires on the edge where the inputs match, cnt==STABLE_CYCLES-1, and s_sel is one-hot. The selected digit k is then processed as follows:
  - One of the 16 encoder patterns (0x40=0, 0x79=1, 0x24=2, 0x30=3, 0x19=4, 0x12=5, 0x02=6, 0x78=7, 0x00=8, 0x10=9, 0x20=A, 0x03=b, 0x46=C, 0x21=d, 0x06=E, 0x0E=F): write the nibble, set valid bit k, pulse o_update.
  - Blank (7'h7F): clear valid bit k, keep the old nibble, pulse o_update, no error.
  - Any other pattern: clear valid bit k, set o_err, pulse o_update.
  - In all three cases, set seen bit k.
- Because cnt saturates, a held pattern captures exactly once. Re-capture requires an input change.
- If s_sel is zero or multi-hot, no capture occurs, the counter runs normally, and the seen mask is unaffected.
- Frame tracking:
  - When the seen mask including the current capture is all ones: pulse o_frame_done in the same cycle as o_update, and clear the seen mask.
  - Simultaneous set and clear resolves to clear.
- o_err clears only on reset.

## Timing
- Reset values: o_value=0, o_valid_mask=0, o_update=0, o_frame_done=0, o_err=0, cnt=0, seen=0.
- Latency: inputs constant from before edge 1 produce an output update at edge STABLE_CYCLES+1. o_update is high for exactly the cycle after that edge.
- STABLE_CYCLES=1: capture on the second edge of a constant input.
- A change of i_seg or i_dig_sel at any point before capture restarts the count from 0.
- i_reset asserted mid-count or mid-frame:
  - All state returns to reset values on that edge.
  - Counting restarts on the first edge with i_reset low.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SEG_DP_EN defined:
  - Adds i_dp (in, 1, active-low decimal point) and o_dp (out, NUM_DIGITS, reset 0).
  - i_dp is sampled and compared alongside i_seg.
  - o_dp[k] is written with ~i_dp on every capture of digit k.
- SEG_DP_EN undefined: the ports and logic are absent, and behaviour is otherwise identical.

## Structure
- Package seg_pkg holds:
  - the SEG_BLANK constant (7'h7F);
  - the 16 digit pattern constants, shared with the encoder side;
  - typedef seg_t (logic [6:0]) and typedef nibble_t (logic [3:0]).
- Sub-module seg_pattern_decoder: combinational, seg_t in → nibble_t, is_hex, is_blank. The top contains only sampling, counting, capture and frame logic.

## Test plan
- NUM_DIGITS=4, STABLE_CYCLES=4; hold sel=4'b0001, seg=0x30 for 6 cycles → o_value[3:0]=3, o_valid_mask=0001, single o_update at edge 5, no repeat.
- Scan sel 0001/0010/0100/1000 with patterns 0x40, 0x79, 0x0E, 0x21, 5 cycles each → o_value=16'hDF10, mask=1111, o_frame_done pulses with the fourth capture.
- Toggle seg between 0x40 and 0x79 every 3 cycles with sel fixed → no capture, o_update stays 0.
- Hold pattern 0x7E on digit 2 → o_err=1 and stays 1, valid bit 2=0. Then hold blank on digit 2 → o_err remains 1, no new error.
- sel=4'b0011 held for 10 cycles → no capture. Assert i_reset at cnt=2 of a valid digit → all outputs 0, and capture occurs 5 edges after release.
- With SEG_DP_EN: digit 0 held at 0x12 with i_dp=0 → o_value[3:0]=5, o_dp[0]=1.
